// File: rtl/beh_reset_monitor.sv
// Passive checker for a grouped reset/start release sequence: tracks the release phase,
// counts reset length and re-assertions, and latches the first protocol violation.
module beh_reset_monitor #(
    parameter int RESETS           = 1,
    parameter int STARTS           = 0,
    parameter int STEPS            = 0,
    parameter int DELAYS           = 0,
    parameter int CAPTURES         = 0,
    parameter int CUTSCANS         = 0,
    parameter int PASSTHRUS        = 0,
    parameter int INJECTS          = 0,
    parameter int MIN_RESET_CYCLES = 10,
    parameter int MIN_START_CYCLES = 10,
    localparam int W = RESETS + STARTS + STEPS + DELAYS + CAPTURES + CUTSCANS + PASSTHRUS + INJECTS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] reset_n,
    output logic [2:0]   phase,
    output logic         started,
    output logic         err,
    output logic [3:0]   err_code,
    output logic [15:0]  reset_cycles,
    output logic [7:0]   reset_count
);

    localparam int RESET_OFF    = 0;
    localparam int START_OFF    = RESET_OFF + RESETS;
    localparam int STEP_OFF     = START_OFF + STARTS;
    localparam int DELAY_OFF    = STEP_OFF + STEPS;
    localparam int CAPTURE_OFF  = DELAY_OFF + DELAYS;
    localparam int CUTSCAN_OFF  = CAPTURE_OFF + CAPTURES;
    localparam int PASSTHRU_OFF = CUTSCAN_OFF + CUTSCANS;
    localparam int INJECT_OFF   = PASSTHRU_OFF + PASSTHRUS;

    localparam logic [15:0] MIN_RESET_W = 16'(MIN_RESET_CYCLES);
    localparam logic [15:0] MIN_START_W = 16'(MIN_START_CYCLES);

    localparam logic [3:0] ERR_ORDER        = 4'd1;
    localparam logic [3:0] ERR_SHORT_RESET  = 4'd2;
    localparam logic [3:0] ERR_SHORT_START  = 4'd3;
    localparam logic [3:0] ERR_SKEW         = 4'd4;
    localparam logic [3:0] ERR_PASSTHRU     = 4'd5;
    localparam logic [3:0] ERR_DELAY_CHANGE = 4'd6;
    localparam logic [3:0] ERR_START_DROP   = 4'd7;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_ASSERTED = 3'd1,
        PH_RELEASED = 3'd2,
        PH_CAPTURED = 3'd3,
        PH_RUNNING  = 3'd4
    } phase_t;

    // Group masks over the packed vector; a zero-width group yields an empty
    // mask, which reads as both all0 and all1 below.
    logic [W-1:0] reset_mask, start_mask, step_mask, delay_mask, capture_mask, passthru_mask;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign reset_mask[gi]    = (gi >= RESET_OFF)    && (gi < START_OFF);
            assign start_mask[gi]    = (gi >= START_OFF)    && (gi < STEP_OFF);
            assign step_mask[gi]     = (gi >= STEP_OFF)     && (gi < DELAY_OFF);
            assign delay_mask[gi]    = (gi >= DELAY_OFF)    && (gi < CAPTURE_OFF);
            assign capture_mask[gi]  = (gi >= CAPTURE_OFF)  && (gi < CUTSCAN_OFF);
            assign passthru_mask[gi] = (gi >= PASSTHRU_OFF) && (gi < INJECT_OFF);
        end
    endgenerate

    logic reset_all0, reset_all1, start_all0, start_all1, step_all0, step_all1;
    logic capture_all0, capture_all1, passthru_all1;

    assign reset_all0    = (reset_n & reset_mask) == '0;
    assign reset_all1    = (reset_n & reset_mask) == reset_mask;
    assign start_all0    = (reset_n & start_mask) == '0;
    assign start_all1    = (reset_n & start_mask) == start_mask;
    assign step_all0     = (reset_n & step_mask) == '0;
    assign step_all1     = (reset_n & step_mask) == step_mask;
    assign capture_all0  = (reset_n & capture_mask) == '0;
    assign capture_all1  = (reset_n & capture_mask) == capture_mask;
    assign passthru_all1 = (reset_n & passthru_mask) == passthru_mask;

    phase_t        phase_reg, phase_next;
    logic [15:0]   reset_cycles_reg, reset_cycles_next;
    logic [7:0]    reset_count_reg, reset_count_next;
    logic [15:0]   gap_reg, gap_next;
    logic [W-1:0]  delay_reg, delay_next;
    logic          err_reg, err_next;
    logic [3:0]    err_code_reg, err_code_next;

    logic [15:0] rc_inc, gap_inc;
    logic [7:0]  cnt_inc;
    logic f_order, f_short_reset, f_short_start, f_skew, f_passthru, f_delay_change, f_start_drop;
    logic [3:0] first_code;

    assign rc_inc  = (reset_cycles_reg == 16'hFFFF) ? reset_cycles_reg : reset_cycles_reg + 16'd1;
    assign gap_inc = (gap_reg == 16'hFFFF) ? gap_reg : gap_reg + 16'd1;
    assign cnt_inc = (reset_count_reg == 8'hFF) ? reset_count_reg : reset_count_reg + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg        <= PH_IDLE;
            reset_cycles_reg <= '0;
            reset_count_reg  <= '0;
            gap_reg          <= '0;
            delay_reg        <= '0;
            err_reg          <= 1'b0;
            err_code_reg     <= '0;
        end else begin
            phase_reg        <= phase_next;
            reset_cycles_reg <= reset_cycles_next;
            reset_count_reg  <= reset_count_next;
            gap_reg          <= gap_next;
            delay_reg        <= delay_next;
            err_reg          <= err_next;
            err_code_reg     <= err_code_next;
        end
    end

    always_comb begin
        phase_next        = phase_reg;
        reset_cycles_next = reset_cycles_reg;
        reset_count_next  = reset_count_reg;
        gap_next          = gap_reg;
        delay_next        = delay_reg;
        f_order           = 1'b0;
        f_short_reset     = 1'b0;
        f_short_start     = 1'b0;
        f_skew            = 1'b0;
        f_passthru        = 1'b0;
        f_delay_change    = 1'b0;
        f_start_drop      = 1'b0;

        if (phase_reg != PH_IDLE) begin
            if ((!reset_all0 && !reset_all1) || (!start_all0 && !start_all1) ||
                (!step_all0 && !step_all1) || (!capture_all0 && !capture_all1))
                f_skew = 1'b1;
            if ((STARTS > 0) && (STEPS > 0) &&
                ((start_all1 && step_all0) || (start_all0 && step_all1)))
                f_skew = 1'b1;
        end

        case (phase_reg)
            PH_IDLE: begin
                if (reset_all0) begin
                    phase_next        = PH_ASSERTED;
                    reset_cycles_next = 16'd1;
                end
            end
            PH_ASSERTED: begin
                reset_cycles_next = rc_inc;
                if ((reset_n & (start_mask | step_mask | capture_mask)) != '0)
                    f_order = 1'b1;
                if (reset_all1) begin
                    f_short_reset = reset_cycles_reg < MIN_RESET_W;
                    f_passthru    = !passthru_all1;
                    delay_next    = reset_n & delay_mask;
                    gap_next      = '0;
                    phase_next    = PH_RELEASED;
                end
            end
            PH_RELEASED, PH_CAPTURED, PH_RUNNING: begin
                // The gap includes the current sample, so a step N cycles after the
                // previous one sees gap == N.
                gap_next       = gap_inc;
                f_delay_change = (reset_n & delay_mask) != delay_reg;
                if (reset_all0) begin
                    phase_next        = PH_ASSERTED;
                    reset_cycles_next = 16'd1;
                    reset_count_next  = cnt_inc;
                end else if (reset_all1) begin
                    if (phase_reg == PH_RUNNING) begin
                        f_start_drop = !(start_all1 && step_all1 && capture_all1);
                    end else if ((phase_reg == PH_RELEASED) && (CAPTURES > 0)) begin
                        if (capture_all1) begin
                            phase_next    = PH_CAPTURED;
                            f_short_start = gap_inc < MIN_START_W;
                            gap_next      = '0;
                        end else if ((reset_n & (start_mask | step_mask)) != '0) begin
                            f_order = 1'b1;
                        end
                    end else if (start_all1 && step_all1) begin
                        phase_next    = PH_RUNNING;
                        f_short_start = ((STARTS + STEPS) != 0) && (gap_inc < MIN_START_W);
                    end
                end
            end
            default: phase_next = PH_IDLE;
        endcase
    end

    // Several violations in one sample report the lowest code.
    always_comb begin
        first_code = '0;
        if      (f_order)        first_code = ERR_ORDER;
        else if (f_short_reset)  first_code = ERR_SHORT_RESET;
        else if (f_short_start)  first_code = ERR_SHORT_START;
        else if (f_skew)         first_code = ERR_SKEW;
        else if (f_passthru)     first_code = ERR_PASSTHRU;
        else if (f_delay_change) first_code = ERR_DELAY_CHANGE;
        else if (f_start_drop)   first_code = ERR_START_DROP;
    end

    always_comb begin
        err_next      = err_reg;
        err_code_next = err_code_reg;
        if (!err_reg && (first_code != '0)) begin
            err_next      = 1'b1;
            err_code_next = first_code;
        end
    end

    assign phase        = phase_reg;
    assign started      = (phase_reg == PH_RUNNING);
    assign err          = err_reg;
    assign err_code     = err_code_reg;
    assign reset_cycles = reset_cycles_reg;
    assign reset_count  = reset_count_reg;

endmodule

// File: tb/tb_beh_reset_monitor.sv
// Directed-vector bench for beh_reset_monitor with two reset bits and one bit in each
// of the START, STEP, DELAY, CAPTURE and PASSTHRU groups.
module tb_beh_reset_monitor;

    localparam int W = 7;  // {PASSTHRU, CAPTURE, DELAY, STEP, START, RESET[1:0]}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] reset_n = 7'b1000000;
    logic [2:0]   phase;
    logic         started;
    logic         err;
    logic [3:0]   err_code;
    logic [15:0]  reset_cycles;
    logic [7:0]   reset_count;

    int n_checks = 0;
    int n_fail   = 0;

    beh_reset_monitor #(
        .RESETS(2), .STARTS(1), .STEPS(1), .DELAYS(1), .CAPTURES(1),
        .CUTSCANS(0), .PASSTHRUS(1), .INJECTS(0),
        .MIN_RESET_CYCLES(10), .MIN_START_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reset_n(reset_n),
        .phase(phase),
        .started(started),
        .err(err),
        .err_code(err_code),
        .reset_cycles(reset_cycles),
        .reset_count(reset_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one vector for n cycles; outputs are sampled 1 time unit after the last edge.
    task automatic apply(input logic [1:0] r, input logic st, input logic sp, input logic cp,
                         input logic dl, input logic ps, input int n);
        reset_n = {ps, cp, dl, sp, st, r};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst     = 1'b1;
        reset_n = 7'b1000000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_phase"},   32'(phase), 0);
        check({tag, "_started"}, 32'(started), 0);
        check({tag, "_err"},     32'(err), 0);
        check({tag, "_code"},    32'(err_code), 0);
        check({tag, "_rcyc"},    32'(reset_cycles), 0);
        check({tag, "_rcnt"},    32'(reset_count), 0);
    endtask

    // From ASSERTED with 10 cycles of reset: release, capture at +10, start/step at +10.
    task automatic release_to_running(input string tag);
        apply(2'b11, 0, 0, 0, 0, 1, 1);
        check({tag, "_released"}, 32'(phase), 2);
        apply(2'b11, 0, 0, 0, 0, 1, 9);
        check({tag, "_wait_cap"}, 32'(phase), 2);
        apply(2'b11, 0, 0, 1, 0, 1, 1);
        check({tag, "_captured"}, 32'(phase), 3);
        apply(2'b11, 0, 0, 1, 0, 1, 9);
        check({tag, "_wait_start"}, 32'(phase), 3);
        apply(2'b11, 1, 1, 1, 0, 1, 1);
        check({tag, "_running"}, 32'(phase), 4);
        check({tag, "_started"}, 32'(started), 1);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        do_rst();
        check_cleared("reset");

        // Legal sequence, then re-assertion from RUNNING.
        apply(2'b00, 0, 0, 0, 0, 1, 1);
        check("legal_assert_phase", 32'(phase), 1);
        check("legal_assert_rcyc", 32'(reset_cycles), 1);
        apply(2'b00, 0, 0, 0, 0, 1, 9);
        check("legal_rcyc10", 32'(reset_cycles), 10);
        release_to_running("legal");
        apply(2'b11, 1, 1, 1, 0, 1, 5);
        check("legal_hold_err", 32'(err), 0);
        check("legal_hold_phase", 32'(phase), 4);

        apply(2'b00, 0, 0, 0, 0, 1, 1);
        check("reassert_phase", 32'(phase), 1);
        check("reassert_rcyc", 32'(reset_cycles), 1);
        check("reassert_rcnt", 32'(reset_count), 1);
        check("reassert_err", 32'(err), 0);
        check("reassert_started", 32'(started), 0);

        // Second pass to RUNNING, then a DELAY change, then rst mid-operation.
        apply(2'b00, 0, 0, 0, 0, 1, 9);
        release_to_running("second");
        apply(2'b11, 1, 1, 1, 1, 1, 1);
        check("delay_err", 32'(err), 1);
        check("delay_code", 32'(err_code), 6);
        check("delay_phase", 32'(phase), 4);
        do_rst();
        check_cleared("after_rst");

        // Reset released after only 6 cycles.
        apply(2'b00, 0, 0, 0, 0, 1, 6);
        apply(2'b11, 0, 0, 0, 0, 1, 1);
        check("short_reset_err", 32'(err), 1);
        check("short_reset_code", 32'(err_code), 2);
        check("short_reset_phase", 32'(phase), 2);

        // START while RESET is asserted, followed by a skew that must not overwrite the code.
        do_rst();
        apply(2'b00, 0, 0, 0, 0, 1, 3);
        apply(2'b00, 1, 0, 0, 0, 1, 1);
        check("order_err", 32'(err), 1);
        check("order_code", 32'(err_code), 1);
        apply(2'b01, 0, 0, 0, 0, 1, 1);
        check("order_sticky_code", 32'(err_code), 1);

        // Split RESET group for a single sample.
        do_rst();
        apply(2'b00, 0, 0, 0, 0, 1, 3);
        apply(2'b01, 0, 0, 0, 0, 1, 1);
        check("skew_code", 32'(err_code), 4);
        check("skew_phase", 32'(phase), 1);

        // Capture only 5 cycles after release.
        do_rst();
        apply(2'b00, 0, 0, 0, 0, 1, 10);
        apply(2'b11, 0, 0, 0, 0, 1, 5);
        apply(2'b11, 0, 0, 1, 0, 1, 1);
        check("short_start_code", 32'(err_code), 3);
        check("short_start_phase", 32'(phase), 3);

        // PASSTHRU low at release.
        do_rst();
        apply(2'b00, 0, 0, 0, 0, 0, 10);
        apply(2'b11, 0, 0, 0, 0, 0, 1);
        check("passthru_code", 32'(err_code), 5);
        check("passthru_phase", 32'(phase), 2);

        // CAPTURE drops while running.
        do_rst();
        apply(2'b00, 0, 0, 0, 0, 1, 10);
        release_to_running("drop");
        apply(2'b11, 1, 1, 0, 0, 1, 1);
        check("start_drop_code", 32'(err_code), 7);
        check("start_drop_phase", 32'(phase), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
